// File: rtl/char_action_fsm_if.sv
// Interface between the character input handler and the action state machine.
// The FSM is the slave; the producer of the strobes (or a bench) is the master.
interface char_action_fsm_if;
  logic       in_left;
  logic       in_right;
  logic       in_attack;
  logic       hit_in;
  logic [9:0] pos_x;
  logic [2:0] state;
  logic       dir_attack;
  logic       attack_active;
  logic [4:0] phase_cnt;
  logic       busy;

  modport master (
    output in_left, in_right, in_attack, hit_in,
    input  pos_x, state, dir_attack, attack_active, phase_cnt, busy
  );

  modport slave (
    input  in_left, in_right, in_attack, hit_in,
    output pos_x, state, dir_attack, attack_active, phase_cnt, busy
  );
endinterface

// File: rtl/char_action_fsm.sv
// Per-character action FSM: walking with saturating position, neutral and
// directional attacks with fixed phase lengths, and hit stun override.
//
// state        | meaning
// IDLE         | standing, inputs sampled every frame
// WALK_FWD     | moving toward the opponent this frame
// WALK_BACK    | moving away from the opponent this frame
// ATK_STARTUP  | attack wind-up, hitbox not yet out
// ATK_ACTIVE   | hitbox live
// ATK_RECOVERY | attack cool-down
// STUN         | hit stun, overrides everything
module char_action_fsm #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 576,
  parameter int X_INIT       = 64,
  parameter int FACING_RIGHT = 1,
  parameter int FWD_SPEED    = 3,
  parameter int BACK_SPEED   = 2,
  parameter int N_STARTUP    = 5,
  parameter int N_ACTIVE     = 2,
  parameter int N_RECOVERY   = 16,
  parameter int D_STARTUP    = 4,
  parameter int D_ACTIVE     = 3,
  parameter int D_RECOVERY   = 15,
  parameter int STUN_FRAMES  = 20
) (
  input  logic clk_game,
  input  logic reset,
  char_action_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WALK_FWD     = 3'd1,
    WALK_BACK    = 3'd2,
    ATK_STARTUP  = 3'd3,
    ATK_ACTIVE   = 3'd4,
    ATK_RECOVERY = 3'd5,
    STUN         = 3'd6
  } state_t;

  localparam logic        FACE     = (FACING_RIGHT != 0);
  localparam logic [10:0] XMIN11   = 11'(X_MIN);
  localparam logic [10:0] XMAX11   = 11'(X_MAX);
  localparam logic [9:0]  XMIN10   = 10'(X_MIN);
  localparam logic [9:0]  XMAX10   = 10'(X_MAX);
  localparam logic [9:0]  XINIT10  = 10'(X_INIT);
  localparam logic [10:0] FWD11    = 11'(FWD_SPEED);
  localparam logic [10:0] BACK11   = 11'(BACK_SPEED);
  localparam logic [4:0]  N_S_LD   = 5'(N_STARTUP - 1);
  localparam logic [4:0]  N_A_LD   = 5'(N_ACTIVE - 1);
  localparam logic [4:0]  N_R_LD   = 5'(N_RECOVERY - 1);
  localparam logic [4:0]  D_S_LD   = 5'(D_STARTUP - 1);
  localparam logic [4:0]  D_A_LD   = 5'(D_ACTIVE - 1);
  localparam logic [4:0]  D_R_LD   = 5'(D_RECOVERY - 1);
  localparam logic [4:0]  STUN_LD  = 5'(STUN_FRAMES - 1);

  state_t      st_q, st_d;
  logic [9:0]  pos_q, pos_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        active_q, active_d;
  logic        busy_q, busy_d;

  logic        one_dir;
  logic        fwd;
  logic [10:0] step;
  logic [10:0] sum;
  logic [10:0] diff;
  logic [9:0]  pos_up;
  logic [9:0]  pos_dn;

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      pos_q    <= XINIT10;
      cnt_q    <= 5'd0;
      dir_q    <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      active_q <= active_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    one_dir = bus.in_left ^ bus.in_right;
    fwd     = (bus.in_right == FACE);
    step    = fwd ? FWD11 : BACK11;
    // 11-bit arithmetic so an underflow shows up in bit 10 instead of wrapping
    sum     = {1'b0, pos_q} + step;
    diff    = {1'b0, pos_q} - step;
    pos_up  = (sum > XMAX11) ? XMAX10 : sum[9:0];
    pos_dn  = (diff[10] || (diff < XMIN11)) ? XMIN10 : diff[9:0];

    if (bus.hit_in) begin
      st_d  = STUN;
      cnt_d = STUN_LD;
    end else begin
      case (st_q)
        IDLE, WALK_FWD, WALK_BACK: begin
          cnt_d = 5'd0;
          if (bus.in_attack) begin
            st_d  = ATK_STARTUP;
            dir_d = one_dir;
            cnt_d = one_dir ? D_S_LD : N_S_LD;
          end else if (one_dir) begin
            st_d  = fwd ? WALK_FWD : WALK_BACK;
            pos_d = bus.in_right ? pos_up : pos_dn;
          end else begin
            st_d = IDLE;
          end
        end
        ATK_STARTUP: begin
          if (cnt_q == 5'd0) begin
            st_d  = ATK_ACTIVE;
            cnt_d = dir_q ? D_A_LD : N_A_LD;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        ATK_ACTIVE: begin
          if (cnt_q == 5'd0) begin
            st_d  = ATK_RECOVERY;
            cnt_d = dir_q ? D_R_LD : N_R_LD;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        ATK_RECOVERY, STUN: begin
          if (cnt_q == 5'd0) begin
            st_d  = IDLE;
            cnt_d = 5'd0;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = 5'd0;
        end
      endcase
    end

    // decoded from the next state so the flag flops line up with st_q
    active_d = (st_d == ATK_ACTIVE);
    busy_d   = (st_d == ATK_STARTUP) || (st_d == ATK_ACTIVE) ||
               (st_d == ATK_RECOVERY) || (st_d == STUN);
  end

  assign bus.pos_x         = pos_q;
  assign bus.state         = st_q;
  assign bus.dir_attack    = dir_q;
  assign bus.attack_active = active_q;
  assign bus.phase_cnt     = cnt_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_char_action_fsm.sv
// Bench for char_action_fsm: directed table, multi-frame corner sequences and
// randomized frames against a frame-schedule reference model.
module tb_char_action_fsm;
  localparam int X_MIN = 0, X_MAX = 576, X_INIT = 64;
  localparam int FWD = 3, BACK = 2;
  localparam int NS = 5, NA = 2, NR = 16, DS = 4, DA = 3, DR = 15, STUNF = 20;

  logic clk_game = 1'b0;
  logic reset;
  char_action_fsm_if bus ();

  char_action_fsm dut (.clk_game(clk_game), .reset(reset), .bus(bus));

  always #5 clk_game = ~clk_game;

  int checks = 0;
  int failures = 0;

  // Model: a queue holding one state code per remaining busy frame.
  int q_sched[$];
  int m_walk;
  int m_pos;
  bit m_dir;

  typedef struct {
    bit l, r, a, h;
    int exp_state;
    int exp_pos;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_sched.delete();
    m_walk = 0;
    m_pos  = X_INIT;
    m_dir  = 1'b0;
  endtask

  task automatic push_n(input int code, input int n);
    for (int i = 0; i < n; i++) q_sched.push_back(code);
  endtask

  function automatic int m_state();
    return (q_sched.size() > 0) ? q_sched[0] : m_walk;
  endfunction

  function automatic int m_cnt();
    int n = 0;
    if (q_sched.size() == 0) return 0;
    foreach (q_sched[i]) begin
      if (q_sched[i] != q_sched[0]) break;
      n++;
    end
    return n - 1;
  endfunction

  task automatic model_step(input bit l, input bit r, input bit a, input bit h);
    bit one = l ^ r;
    if (h) begin
      q_sched.delete();
      push_n(6, STUNF);
      m_walk = 0;
    end else if (q_sched.size() > 0) begin
      void'(q_sched.pop_front());
      m_walk = 0;
    end else if (a) begin
      m_dir = one;
      if (one) begin push_n(3, DS); push_n(4, DA); push_n(5, DR); end
      else     begin push_n(3, NS); push_n(4, NA); push_n(5, NR); end
      m_walk = 0;
    end else if (one) begin
      // FACING_RIGHT=1: right is forward
      m_walk = r ? 1 : 2;
      if (r) m_pos = (m_pos + FWD > X_MAX) ? X_MAX : m_pos + FWD;
      else   m_pos = (m_pos - BACK < X_MIN) ? X_MIN : m_pos - BACK;
    end else begin
      m_walk = 0;
    end
  endtask

  task automatic cmp_model();
    int s = m_state();
    chk("state", int'(bus.state), s);
    chk("pos_x", int'(bus.pos_x), m_pos);
    chk("phase_cnt", int'(bus.phase_cnt), m_cnt());
    chk("dir_attack", int'(bus.dir_attack), int'(m_dir));
    chk("attack_active", int'(bus.attack_active), int'(s == 4));
    chk("busy", int'(bus.busy), int'(s >= 3));
  endtask

  task automatic step(input bit l, input bit r, input bit a, input bit h);
    bus.in_left = l; bus.in_right = r; bus.in_attack = a; bus.hit_in = h;
    @(posedge clk_game);
    model_step(l, r, a, h);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_left = 0; bus.in_right = 0; bus.in_attack = 0; bus.hit_in = 0;
    model_reset();
    #2;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_pos", int'(bus.pos_x), X_INIT);
    chk("rst_cnt", int'(bus.phase_cnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk_game);
    reset = 1'b0;
  endtask

  initial begin
    int n3, n4, n5, nact, pos0;
    bit ok_busy;

    for (int i = 0; i < 10; i++) tbl.push_back('{0, 1, 0, 0, 1, X_INIT + FWD * (i + 1)});
    tbl.push_back('{1, 1, 0, 0, 0, 94});
    tbl.push_back('{1, 0, 0, 0, 2, 92});
    tbl.push_back('{0, 0, 0, 0, 0, 92});

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].h);
      chk($sformatf("tbl%0d_state", i), int'(bus.state), tbl[i].exp_state);
      chk($sformatf("tbl%0d_pos", i), int'(bus.pos_x), tbl[i].exp_pos);
    end

    // neutral attack: 5/2/16 frames, IDLE 23 edges after trigger
    n3 = 0; n4 = 0; n5 = 0; nact = 0;
    for (int i = 0; i < 23; i++) begin
      step(0, 0, (i == 0), 0);
      if (bus.state == 3'd3) n3++;
      if (bus.state == 3'd4) n4++;
      if (bus.state == 3'd5) n5++;
      if (bus.attack_active) nact++;
    end
    chk("n_startup_len", n3, NS);
    chk("n_active_len", n4, NA);
    chk("n_recovery_len", n5, NR);
    chk("n_active_flag_len", nact, NA);
    chk("n_dir", int'(bus.dir_attack), 0);
    step(0, 0, 0, 0);
    chk("n_idle_after", int'(bus.state), 0);
    chk("n_pos_kept", int'(bus.pos_x), 92);

    // directional attack with inputs toggling throughout
    n3 = 0; n4 = 0; n5 = 0; ok_busy = 1'b1; pos0 = int'(bus.pos_x);
    step(1, 0, 1, 0);
    chk("d_dir", int'(bus.dir_attack), 1);
    chk("d_cnt0", int'(bus.phase_cnt), DS - 1);
    n3 = 1;
    for (int i = 0; i < 21; i++) begin
      step($urandom_range(1), $urandom_range(1), $urandom_range(1), 0);
      if (bus.state == 3'd3) n3++;
      if (bus.state == 3'd4) n4++;
      if (bus.state == 3'd5) n5++;
      if (!bus.busy) ok_busy = 1'b0;
    end
    chk("d_startup_len", n3, DS);
    chk("d_active_len", n4, DA);
    chk("d_recovery_len", n5, DR);
    chk("d_busy_all", int'(ok_busy), 1);
    chk("d_pos_const", int'(bus.pos_x), pos0);
    step(1, 0, 1, 0);
    chk("d_exit_ignores", int'(bus.state), 0);
    step(0, 0, 0, 0);

    // hit during ACTIVE, re-hit 5 frames later
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("h_in_active", int'(bus.state), 4);
    step(0, 0, 0, 1);
    chk("h_state", int'(bus.state), 6);
    chk("h_active_off", int'(bus.attack_active), 0);
    chk("h_cnt", int'(bus.phase_cnt), STUNF - 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    chk("h2_cnt", int'(bus.phase_cnt), STUNF - 1);
    for (int i = 0; i < 19; i++) step(0, 1, 1, 0);
    chk("h2_still_stun", int'(bus.state), 6);
    step(0, 0, 0, 0);
    chk("h2_idle", int'(bus.state), 0);

    // saturation at both bounds
    do_reset();
    for (int i = 0; i < 35; i++) step(1, 0, 0, 0);
    chk("sat_lo_pos", int'(bus.pos_x), X_MIN);
    chk("sat_lo_state", int'(bus.state), 2);
    for (int i = 0; i < 195; i++) step(0, 1, 0, 0);
    chk("sat_hi_pos", int'(bus.pos_x), X_MAX);
    chk("sat_hi_state", int'(bus.state), 1);
    step(1, 1, 0, 0);
    chk("both_idle", int'(bus.state), 0);
    chk("both_pos", int'(bus.pos_x), X_MAX);

    // async reset mid-recovery
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("ar_in_recovery", int'(bus.state), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pos", int'(bus.pos_x), X_INIT);
    chk("ar_state", int'(bus.state), 0);
    chk("ar_cnt", int'(bus.phase_cnt), 0);
    chk("ar_busy", int'(bus.busy), 0);
    model_reset();
    @(negedge clk_game);
    reset = 1'b0;

    // random frames against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(1), $urandom_range(1),
           ($urandom_range(5) == 0), ($urandom_range(39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
